log2_iter: RTL and testbench
============================

LOG2_ITER -- requirements
Module: log2_iter

Interface
REQ-001 Parameter DW, default 16: input/output word width.
REQ-002 Parameter IN_FRAC, default 13: input fraction bits (Q2.13, sign bit MSB).
REQ-003 Parameter OUT_FRAC, default 10: output fraction bits (signed Q5.10).
REQ-004 I_CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 I_RST_N  input  1  reset, asynchronous and active-low.
REQ-006 I_VALID  input  1  upstream operand valid.
REQ-007 I_X  input  DW  operand, Q2.13, SHALL be strictly positive.
REQ-008 O_READY  output  1  block can accept an operand.
REQ-009 O_VALID  output  1  result valid, held until consumed.
REQ-010 O_LOG  output  DW  log2(I_X), signed Q5.10.
REQ-011 O_ERR  output  1  operand was zero or negative, qualified by O_VALID.
REQ-012 I_READY  input  1  downstream accepts result.

Function
REQ-013 FSM states IDLE, NORM, CALC, DONE; O_READY=1 only in IDLE; O_VALID=1 only in DONE.
REQ-014 IDLE: I_VALID&O_READY captures I_X into x_r, clears shift counter s; goes to NORM if I_X>0 (signed), else to CALC with error flag set.
REQ-015 NORM: if x_r[14]=1 go to CALC; else x_r<=x_r<<1, s<=s+1, stay (one bit per cycle, s max 14).
REQ-016 CALC: e=1-s (signed), m=x_r[13:0] (Q0.14); result registered into O_LOG; go to DONE.
REQ-017 Arithmetic: O_LOG = (e<<10) + ((m+corr)>>4), truncating shift, 16-bit two's complement; no overflow possible for legal inputs (range -13..+2).
REQ-018 Correction: m<8192: corr=(m>>3)+(m>>4); else d=16384-m, corr=(d>>3)+(d>>4).
REQ-019 Error path: O_LOG=16'h8000, O_ERR=1; O_ERR=0 for all legal results.
REQ-020 DONE: O_LOG/O_ERR held stable; on I_READY=1 go to IDLE; I_READY while O_VALID=0 ignored.
REQ-021 Latency: O_VALID asserts s+3 cycles after the accepting edge for legal operands, 2 cycles for error operands.
REQ-022 I_X and I_VALID ignored outside IDLE; no operand queuing.

Reset
REQ-023 I_RST_N low SHALL immediately force IDLE, O_READY=1, O_VALID=0, O_LOG=0, O_ERR=0, x_r=0, s=0, including mid-NORM; in-flight operand discarded.
REQ-024 First acceptance possible on the first rising edge after I_RST_N deasserts.

Configuration
REQ-025 Macro LOG2_CORR_EN defined: REQ-018 correction compiled in; undefined: corr=0 (pure Mitchell approximation), latency unchanged.

Structure
REQ-026 Package mha_fix_pkg SHALL hold Q-format constants (IN_FRAC, OUT_FRAC, ERR_CODE 16'h8000) and the FSM state enum.
REQ-027 Correction term SHALL be a combinational sub-module log2_mant_corr (m in, corr out), instantiated only under LOG2_CORR_EN.

Verification
REQ-028 I_X=16'h4000 (2.0) -> O_LOG=16'h0400, O_ERR=0, O_VALID 3 cycles after accept.
REQ-029 I_X=16'h6000 (3.0) -> O_LOG=16'h0660 with LOG2_CORR_EN, 16'h0600 without.
REQ-030 I_X=16'h0001 -> s=14, O_LOG=16'hCC00 (-13.0), O_VALID 17 cycles after accept.
REQ-031 I_X=16'h0000 and 16'h8000 -> O_LOG=16'h8000, O_ERR=1, O_VALID 2 cycles after accept.
REQ-032 I_X=16'h2000 with I_READY held 0 for 5 cycles -> O_LOG=16'h0000 stable, O_READY=0 throughout; returns to IDLE cycle after I_READY=1.
REQ-033 I_RST_N pulsed low during NORM of I_X=16'h0001 -> outputs at reset values immediately, O_VALID never asserts for that operand, next operand 16'h4000 yields 16'h0400.

Source files
------------

// File: rtl/mha_fix_pkg.sv
// Shared fixed-point constants and FSM state encoding for the iterative log2 unit.
`timescale 1ns/1ps
package mha_fix_pkg;

    // Word width and Q formats: operand Q2.13, result signed Q5.10.
    localparam int DW       = 16;
    localparam int IN_FRAC  = 13;
    localparam int OUT_FRAC = 10;

    // Result word reported for zero or negative operands (most negative value).
    localparam logic [15:0] ERR_CODE = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/log2_mant_corr.sv
// Piecewise-linear correction added to the Mitchell log2 mantissa.
// corr = 3/16 * m below the midpoint, 3/16 * (1 - m) above it (Q0.MW).
`timescale 1ns/1ps
module log2_mant_corr #(
    parameter int MW = 14
) (
    input  logic [MW-1:0] m,
    output logic [MW-1:0] corr
);

    logic [MW-1:0] d;

    // Fold the upper half onto its distance from 1.0, then scale by 1/8 + 1/16.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        d    = m;
        corr = '0;
        if (m[MW-1]) begin
            // 2^MW - m, taken modulo 2^MW; fits because m >= 2^(MW-1) here.
            d = MW'(0) - m;
        end
        corr = (d >> 3) + (d >> 4);
    end

endmodule

// File: rtl/log2_iter.sv
// Iterative log2 of a positive Q2.13 operand, producing a signed Q5.10 result.
// The operand is normalised one bit per cycle until its integer bit is set; the
// exponent comes from the shift count and the mantissa from the remaining bits.
// Build option: define LOG2_CORR_EN to add the mantissa correction term;
// without it the result is the plain Mitchell approximation (same latency).
`timescale 1ns/1ps
module log2_iter #(
    parameter int DW       = mha_fix_pkg::DW,
    parameter int IN_FRAC  = mha_fix_pkg::IN_FRAC,
    parameter int OUT_FRAC = mha_fix_pkg::OUT_FRAC
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_VALID,
    input  logic [DW-1:0] I_X,
    output logic          O_READY,
    output logic          O_VALID,
    output logic [DW-1:0] O_LOG,
    output logic          O_ERR,
    input  logic          I_READY
);

    import mha_fix_pkg::*;

    // x_r keeps the integer bit plus the fraction; the sign bit is only needed at capture.
    localparam int XW  = IN_FRAC + 2;
    localparam int MW  = IN_FRAC + 1;
    localparam int SW  = $clog2(XW);
    localparam int RSH = MW - OUT_FRAC;

    state_t         state;
    state_t         state_nxt;
    logic [XW-1:0]  x_r;
    logic [SW-1:0]  s;
    logic           err_r;
    logic           x_pos;
    logic [MW-1:0]  m;
    logic [MW-1:0]  corr;
    logic [MW:0]    m_sum;
    logic [DW-1:0]  exp_term;
    logic [DW-1:0]  frac_term;
    logic [DW-1:0]  log_val;

    assign x_pos = !I_X[DW-1] && (I_X != '0);

    // Mantissa below the normalised integer bit, as Q0.MW.
    assign m = x_r[MW-1:0];

`ifdef LOG2_CORR_EN
    log2_mant_corr #(
        .MW   (MW)
    ) u_mant_corr (
        .m    (m),
        .corr (corr)
    );
`else
    assign corr = '0;
`endif

    // Exponent 1 - s in two's complement, placed above the output fraction.
    assign exp_term  = (DW'(1) - DW'(s)) << OUT_FRAC;
    assign m_sum     = {1'b0, m} + {1'b0, corr};
    assign frac_term = DW'(m_sum >> RSH);
    assign log_val   = exp_term + frac_term;

    // State register.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!I_RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        O_READY   = 1'b0;
        O_VALID   = 1'b0;
        unique case (state)
            IDLE: begin
                O_READY = 1'b1;
                if (I_VALID) begin
                    state_nxt = x_pos ? NORM : CALC;
                end
            end
            NORM: begin
                if (x_r[XW-1]) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = DONE;
            end
            DONE: begin
                O_VALID = 1'b1;
                if (I_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, normalisation shifts and result register.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            x_r   <= '0;
            s     <= '0;
            err_r <= 1'b0;
            O_LOG <= '0;
            O_ERR <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (I_VALID) begin
                        x_r   <= I_X[XW-1:0];
                        s     <= '0;
                        err_r <= !x_pos;
                    end
                end
                NORM: begin
                    if (!x_r[XW-1]) begin
                        x_r <= x_r << 1;
                        s   <= s + SW'(1);
                    end
                end
                CALC: begin
                    if (err_r) begin
                        O_LOG <= DW'(ERR_CODE);
                        O_ERR <= 1'b1;
                    end else begin
                        O_LOG <= log_val;
                        O_ERR <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log2_iter.sv
// Scoreboard bench for log2_iter: the driver pushes the expected result when an
// operand is accepted; a monitor pops and compares whenever O_VALID rises.
`timescale 1ns/1ps
module tb_log2_iter;

    logic        I_CLK;
    logic        I_RST_N;
    logic        I_VALID;
    logic [15:0] I_X;
    logic        O_READY;
    logic        O_VALID;
    logic [15:0] O_LOG;
    logic        O_ERR;
    logic        I_READY;

    typedef struct {
        logic [15:0] x;
        logic [15:0] log_v;
        logic        err;
        int          lat;
        longint      t_acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   in_done;
    int   n_checks;
    int   n_fail;

`ifdef LOG2_CORR_EN
    localparam logic [15:0] LOG_3P0   = 16'h0660;
    localparam logic [15:0] LOG_2P5   = 16'h0530;
    localparam logic [15:0] LOG_0P375 = 16'hFA60;
    localparam logic [15:0] LOG_X0003 = 16'hD260;
`else
    localparam logic [15:0] LOG_3P0   = 16'h0600;
    localparam logic [15:0] LOG_2P5   = 16'h0500;
    localparam logic [15:0] LOG_0P375 = 16'hFA00;
    localparam logic [15:0] LOG_X0003 = 16'hD200;
`endif

    log2_iter dut (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_VALID (I_VALID),
        .I_X     (I_X),
        .O_READY (O_READY),
        .O_VALID (O_VALID),
        .O_LOG   (O_LOG),
        .O_ERR   (O_ERR),
        .I_READY (I_READY)
    );

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: first cycle of O_VALID pops the scoreboard; later cycles check the hold.
    always @(negedge I_CLK) begin
        if (!I_RST_N) begin
            in_done = 1'b0;
        end else if (O_VALID) begin
            if (!in_done) begin
                in_done = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(O_VALID), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check($sformatf("log_%04h", cur.x), 32'(O_LOG), 32'(cur.log_v));
                    check($sformatf("err_%04h", cur.x), 32'(O_ERR), 32'(cur.err));
                    check($sformatf("lat_%04h", cur.x),
                          32'(int'((longint'($time) - 5 - cur.t_acc) / 10) + 1), 32'(cur.lat));
                end
            end else begin
                check("hold_log", 32'(O_LOG), 32'(cur.log_v));
                check("hold_err", 32'(O_ERR), 32'(cur.err));
                check("hold_ready", 32'(O_READY), 32'd0);
            end
        end else begin
            in_done = 1'b0;
        end
    end

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        @(negedge I_CLK);
        while (!O_READY && n < 50) begin
            @(negedge I_CLK);
            n++;
        end
        ok = O_READY;
        if (!ok) check("ready_timeout", 32'(O_READY), 32'd1);
    endtask

    // Present an operand at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [15:0] x, input logic [15:0] lg, input logic er, input int lat);
        exp_t e;
        I_X     = x;
        I_VALID = 1'b1;
        @(posedge I_CLK);
        e.x     = x;
        e.log_v = lg;
        e.err   = er;
        e.lat   = lat;
        e.t_acc = longint'($time);
        sb.push_back(e);
        #1;
        I_VALID = 1'b0;
        I_X     = '0;
    endtask

    // Optionally inject ignored traffic while busy, wait for the result, stall, consume.
    task automatic complete(input int hold, input bit noise);
        int n;
        if (noise) begin
            repeat (2) @(negedge I_CLK);
            I_VALID = 1'b1;
            I_X     = 16'h7FFF;
            I_READY = 1'b1;
            repeat (6) @(negedge I_CLK);
            I_VALID = 1'b0;
            I_X     = '0;
            I_READY = 1'b0;
        end
        n = 0;
        while (!O_VALID && n < 40) begin
            @(negedge I_CLK);
            n++;
        end
        if (!O_VALID) begin
            check("valid_timeout", 32'(O_VALID), 32'd1);
            return;
        end
        repeat (hold) @(negedge I_CLK);
        I_READY = 1'b1;
        @(posedge I_CLK);
        #1;
        I_READY = 1'b0;
        check("return_idle_ready", 32'(O_READY), 32'd1);
        check("return_idle_valid", 32'(O_VALID), 32'd0);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] lg, input logic er,
                        input int lat, input int hold, input bit noise);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        issue(x, lg, er, lat);
        complete(hold, noise);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        in_done  = 1'b0;
        I_RST_N  = 1'b0;
        I_VALID  = 1'b0;
        I_READY  = 1'b0;
        I_X      = '0;
        #2;
        check("rst_ready", 32'(O_READY), 32'd1);
        check("rst_valid", 32'(O_VALID), 32'd0);
        check("rst_log",   32'(O_LOG),   32'd0);
        check("rst_err",   32'(O_ERR),   32'd0);
        repeat (2) @(negedge I_CLK);
        I_RST_N = 1'b1;

        //    operand   expected    err   lat hold noise
        send(16'h4000, 16'h0400,   1'b0,  3,  0, 1'b0);   // 2.0
        send(16'h6000, LOG_3P0,    1'b0,  3,  0, 1'b0);   // 3.0
        send(16'h0001, 16'hCC00,   1'b0, 17,  1, 1'b1);   // smallest positive, s = 14
        send(16'h0000, 16'h8000,   1'b1,  2,  0, 1'b0);   // zero
        send(16'h8000, 16'h8000,   1'b1,  2,  2, 1'b0);   // most negative
        send(16'h2000, 16'h0000,   1'b0,  4,  5, 1'b0);   // 1.0, stalled downstream
        send(16'h7FFF, 16'h07FF,   1'b0,  3,  0, 1'b0);   // largest positive
        send(16'hFFFF, 16'h8000,   1'b1,  2,  0, 1'b0);   // -1 LSB
        send(16'h1000, 16'hFC00,   1'b0,  5,  0, 1'b0);   // 0.5
        send(16'h0C00, LOG_0P375,  1'b0,  6,  0, 1'b0);   // 0.375
        send(16'h5000, LOG_2P5,    1'b0,  3,  0, 1'b0);   // 2.5
        send(16'h0003, LOG_X0003,  1'b0, 16,  0, 1'b0);   // s = 13

        // Reset in the middle of normalisation discards the operand.
        @(negedge I_CLK);
        I_X     = 16'h0001;
        I_VALID = 1'b1;
        @(posedge I_CLK);
        #1;
        I_VALID = 1'b0;
        I_X     = '0;
        repeat (4) @(negedge I_CLK);
        #2;
        I_RST_N = 1'b0;
        #1;
        check("midrst_ready", 32'(O_READY), 32'd1);
        check("midrst_valid", 32'(O_VALID), 32'd0);
        check("midrst_log",   32'(O_LOG),   32'd0);
        check("midrst_err",   32'(O_ERR),   32'd0);
        repeat (3) @(negedge I_CLK);
        // Operand presented at release must be taken on the very next rising edge.
        #2;
        I_RST_N = 1'b1;
        issue(16'h4000, 16'h0400, 1'b0, 3);
        complete(0, 1'b0);

        repeat (4) @(negedge I_CLK);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000 ns");
        $fatal(1);
    end

endmodule
